mgmt_gpio_bank: RTL

- Parametrised management GPIO bank: NCH channels, each with an output data bit, an active-low output enable, and a synchronised input.
- Adds a hardware blink generator and per-channel rising/falling-edge interrupts; both replace firmware toggling loops.
- Sits between the management SoC register bus and the mgmt_gpio pad signals.
- Firmware programs it through a simple strobe/ack register port.

---
 rtl/mgmt_gpio_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mgmt_gpio_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mgmt_gpio_bank - management GPIO bank with hardware blink and edge interrupts
// Revision 1.0
// ----------------------------------------------------------------------------
module mgmt_gpio_bank #(
  parameter int          NCH         = 16,
  parameter int          CNT_W       = 24,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned PERIOD_RST  = 999
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [2:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  input  logic             reg_we,
  input  logic             reg_re,
  output logic [31:0]      reg_rdata,
  output logic             reg_ack,
  input  logic [NCH-1:0]   gpio_in,
  output logic [NCH-1:0]   gpio_out,
  output logic [NCH-1:0]   gpio_oeb,
  output logic             irq
);

  localparam logic [2:0] C_ADDR_DATA_OUT   = 3'd0;
  localparam logic [2:0] C_ADDR_DATA_IN    = 3'd1;
  localparam logic [2:0] C_ADDR_OEB        = 3'd2;
  localparam logic [2:0] C_ADDR_BLINK_EN   = 3'd3;
  localparam logic [2:0] C_ADDR_PERIOD     = 3'd4;
  localparam logic [2:0] C_ADDR_RISE_EN    = 3'd5;
  localparam logic [2:0] C_ADDR_FALL_EN    = 3'd6;
  localparam logic [2:0] C_ADDR_IRQ_STATUS = 3'd7;
  localparam logic [CNT_W-1:0] C_PERIOD_RST = CNT_W'(PERIOD_RST);

  logic [NCH-1:0]   r_data_out, r_oeb, r_blink_en, r_rise_en, r_fall_en;
  logic [NCH-1:0]   r_status, r_prev;
  logic [NCH-1:0]   r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_period, r_cnt;
  logic             r_phase;

  logic             w_req, w_wr, w_rd_only, w_blink_restart;
  logic [NCH-1:0]   w_wr_data, w_data_in, w_rise, w_fall, w_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // A strobe held through the ack cycle is not re-accepted until ack drops.
  assign w_req     = (reg_we | reg_re) & ~reg_ack;
  assign w_wr      = w_req & reg_we;
  assign w_rd_only = w_req & reg_re & ~reg_we;
  assign w_wr_data = reg_wdata[NCH-1:0];
  assign w_unused_wdata = ^reg_wdata;

  assign w_data_in = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_data_in & ~r_prev;
  assign w_fall    = ~w_data_in & r_prev;
  assign w_clr     = (w_wr && reg_addr == C_ADDR_IRQ_STATUS) ? w_wr_data : '0;

  assign w_blink_restart = w_wr && ((reg_addr == C_ADDR_PERIOD) ||
                           (reg_addr == C_ADDR_BLINK_EN && r_blink_en == '0 && w_wr_data != '0));

  always_comb begin
    w_rd_mux = '0;
    case (reg_addr)
      C_ADDR_DATA_OUT:   w_rd_mux[NCH-1:0]   = r_data_out;
      C_ADDR_DATA_IN:    w_rd_mux[NCH-1:0]   = w_data_in;
      C_ADDR_OEB:        w_rd_mux[NCH-1:0]   = r_oeb;
      C_ADDR_BLINK_EN:   w_rd_mux[NCH-1:0]   = r_blink_en;
      C_ADDR_PERIOD:     w_rd_mux[CNT_W-1:0] = r_period;
      C_ADDR_RISE_EN:    w_rd_mux[NCH-1:0]   = r_rise_en;
      C_ADDR_FALL_EN:    w_rd_mux[NCH-1:0]   = r_fall_en;
      C_ADDR_IRQ_STATUS: w_rd_mux[NCH-1:0]   = r_status;
      default:           w_rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Shared half-period counter; phase toggles after BLINK_PERIOD+1 cycles.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_blink_restart || r_blink_en == '0) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == r_period) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_data_out <= '0;
      r_oeb      <= '1;
      r_blink_en <= '0;
      r_period   <= C_PERIOD_RST;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_status   <= '0;
      r_prev     <= '0;
      reg_ack    <= 1'b0;
      reg_rdata  <= '0;
      gpio_out   <= '0;
      gpio_oeb   <= '1;
      irq        <= 1'b0;
    end else begin
      reg_ack   <= w_req;
      reg_rdata <= w_rd_only ? w_rd_mux : '0;
      if (w_wr) begin
        case (reg_addr)
          C_ADDR_DATA_OUT: r_data_out <= w_wr_data;
          C_ADDR_OEB:      r_oeb      <= w_wr_data;
          C_ADDR_BLINK_EN: r_blink_en <= w_wr_data;
          C_ADDR_PERIOD:   r_period   <= reg_wdata[CNT_W-1:0];
          C_ADDR_RISE_EN:  r_rise_en  <= w_wr_data;
          C_ADDR_FALL_EN:  r_fall_en  <= w_wr_data;
          default: ;
        endcase
      end
      // New events are OR-ed in after the clear so a coincident event survives.
      r_status <= (r_status & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
      r_prev   <= w_data_in;
      irq      <= |r_status;
      gpio_out <= r_data_out ^ (r_blink_en & {NCH{r_phase}});
      gpio_oeb <= r_oeb;
    end
  end

endmodule
`default_nettype wire
